// File: rtl/reg_file_pkg.sv
// Shared definitions for the register-file access master: default widths, FSM encoding
// and field placement of a command inside the packed FIFO word {write, address, wr_data}.
package reg_file_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int unsigned CMD_DATA_LSB = 0;

  function automatic int unsigned cmd_addr_lsb(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned cmd_write_bit(input int unsigned dw, input int unsigned aw);
    return dw + aw;
  endfunction

  function automatic int unsigned cmd_width(input int unsigned dw, input int unsigned aw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Command, response and register-file strobe signals of the register-file access master.
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_address;
  logic [DATA_WIDTH-1:0] cmd_wr_data;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [ADDR_WIDTH-1:0] rsp_address;
  logic [DATA_WIDTH-1:0] rsp_rd_data;

  logic                  rf_wr_enable;
  logic                  rf_rd_enable;
  logic [ADDR_WIDTH-1:0] rf_address;
  logic [DATA_WIDTH-1:0] rf_wr_data;
  logic [DATA_WIDTH-1:0] rf_rd_data;

  logic                  busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_wr_data, rsp_ready, rf_rd_data,
    output cmd_ready, rsp_valid, rsp_write, rsp_address, rsp_rd_data,
           rf_wr_enable, rf_rd_enable, rf_address, rf_wr_data, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_wr_data, rsp_ready, rf_rd_data,
    input  cmd_ready, rsp_valid, rsp_write, rsp_address, rsp_rd_data,
           rf_wr_enable, rf_rd_enable, rf_address, rf_wr_data, busy
  );

endinterface

// File: rtl/rf_cmd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers; exposes next-cycle full/empty so the
// owner can register its ready/busy flags without a cycle of lag.
module rf_cmd_fifo #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full_nxt_c,
  output logic             empty_nxt_c
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic             full, do_push, do_pop;

  always_comb begin
    do_push     = push && !full;
    do_pop      = pop && !empty;
    wr_ptr_nxt  = wr_ptr + PTR_W'(do_push);
    rd_ptr_nxt  = rd_ptr + PTR_W'(do_pop);
    full_nxt_c  = (wr_ptr_nxt[PTR_W-1] != rd_ptr_nxt[PTR_W-1]) &&
                  (wr_ptr_nxt[IDX_W-1:0] == rd_ptr_nxt[IDX_W-1:0]);
    empty_nxt_c = (wr_ptr_nxt == rd_ptr_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      full   <= full_nxt_c;
      empty  <= empty_nxt_c;
    end
  end

  // Storage needs no reset: entries are only read between a push and its pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IDX_W-1:0]] <= wr_data;
  end

  assign head = mem[rd_ptr[IDX_W-1:0]];

endmodule

// File: rtl/reg_file_master.sv
// Initiator for a register file: buffers commands, issues one strobe per command,
// and returns one response per command with read data or the echoed write data.
module reg_file_master
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input logic        CLK,
  input logic        RST,
  reg_file_if.master bus
);

  localparam int unsigned CMD_W     = cmd_width(DATA_WIDTH, ADDR_WIDTH);
  localparam int unsigned ADDR_LSB  = cmd_addr_lsb(DATA_WIDTH);
  localparam int unsigned WRITE_BIT = cmd_write_bit(DATA_WIDTH, ADDR_WIDTH);
  localparam int unsigned CNT_W     = 3;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  cmd_write, cmd_write_nxt;
  logic                  rf_wr_enable, rf_wr_enable_nxt;
  logic                  rf_rd_enable, rf_rd_enable_nxt;
  logic [ADDR_WIDTH-1:0] rf_address, rf_address_nxt;
  logic [DATA_WIDTH-1:0] rf_wr_data, rf_wr_data_nxt;
  logic                  rsp_valid, rsp_valid_nxt;
  logic                  rsp_write, rsp_write_nxt;
  logic [ADDR_WIDTH-1:0] rsp_address, rsp_address_nxt;
  logic [DATA_WIDTH-1:0] rsp_rd_data, rsp_rd_data_nxt;
  logic                  cmd_ready, cmd_ready_nxt;
  logic                  busy, busy_nxt;

  logic                  fifo_push, fifo_pop, fifo_empty, fifo_full_nxt, fifo_empty_nxt;
  logic [CMD_W-1:0]      fifo_wr, fifo_head;

  assign fifo_push = bus.cmd_valid && cmd_ready;
  assign fifo_wr   = {bus.cmd_write, bus.cmd_address, bus.cmd_wr_data};

  rf_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (CLK),
    .rst_n       (RST),
    .push        (fifo_push),
    .pop         (fifo_pop),
    .wr_data     (fifo_wr),
    .head        (fifo_head),
    .empty       (fifo_empty),
    .full_nxt_c  (fifo_full_nxt),
    .empty_nxt_c (fifo_empty_nxt)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    cmd_write_nxt    = cmd_write;
    rf_wr_enable_nxt = 1'b0;
    rf_rd_enable_nxt = 1'b0;
    rf_address_nxt   = rf_address;
    rf_wr_data_nxt   = rf_wr_data;
    rsp_valid_nxt    = rsp_valid;
    rsp_write_nxt    = rsp_write;
    rsp_address_nxt  = rsp_address;
    rsp_rd_data_nxt  = rsp_rd_data;
    fifo_pop         = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop         = 1'b1;
          cmd_write_nxt    = fifo_head[WRITE_BIT];
          rf_wr_enable_nxt = fifo_head[WRITE_BIT];
          rf_rd_enable_nxt = !fifo_head[WRITE_BIT];
          rf_address_nxt   = fifo_head[ADDR_LSB +: ADDR_WIDTH];
          rf_wr_data_nxt   = fifo_head[CMD_DATA_LSB +: DATA_WIDTH];
          state_nxt        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_write) begin
          rsp_valid_nxt   = 1'b1;
          rsp_write_nxt   = 1'b1;
          rsp_address_nxt = rf_address;
          rsp_rd_data_nxt = rf_wr_data;
          state_nxt       = ST_RESP;
        end else begin
          cnt_nxt   = CNT_W'(RD_LATENCY);
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Last count corresponds to the edge at which read data is valid.
        if (cnt == CNT_W'(1)) begin
          rsp_valid_nxt   = 1'b1;
          rsp_write_nxt   = 1'b0;
          rsp_address_nxt = rf_address;
          rsp_rd_data_nxt = bus.rf_rd_data;
          cnt_nxt         = '0;
          state_nxt       = ST_RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    cmd_ready_nxt = !fifo_full_nxt;
    busy_nxt      = !fifo_empty_nxt || (state_nxt != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      cmd_write    <= 1'b0;
      rf_wr_enable <= 1'b0;
      rf_rd_enable <= 1'b0;
      rf_address   <= '0;
      rf_wr_data   <= '0;
      rsp_valid    <= 1'b0;
      rsp_write    <= 1'b0;
      rsp_address  <= '0;
      rsp_rd_data  <= '0;
      cmd_ready    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      cmd_write    <= cmd_write_nxt;
      rf_wr_enable <= rf_wr_enable_nxt;
      rf_rd_enable <= rf_rd_enable_nxt;
      rf_address   <= rf_address_nxt;
      rf_wr_data   <= rf_wr_data_nxt;
      rsp_valid    <= rsp_valid_nxt;
      rsp_write    <= rsp_write_nxt;
      rsp_address  <= rsp_address_nxt;
      rsp_rd_data  <= rsp_rd_data_nxt;
      cmd_ready    <= cmd_ready_nxt;
      busy         <= busy_nxt;
    end
  end

  assign bus.cmd_ready    = cmd_ready;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_write    = rsp_write;
  assign bus.rsp_address  = rsp_address;
  assign bus.rsp_rd_data  = rsp_rd_data;
  assign bus.rf_wr_enable = rf_wr_enable;
  assign bus.rf_rd_enable = rf_rd_enable;
  assign bus.rf_address   = rf_address;
  assign bus.rf_wr_data   = rf_wr_data;
  assign bus.busy         = busy;

endmodule
